// File: rtl/spi_minion_adapter.sv
// Frame-level bridge between an SPI minion push/pull port and val/rdy streams.
// Status is snapshotted at frame start and queue updates are committed at frame end.
module spi_minion_adapter #(
  parameter int nbits       = 8,
  parameter int num_entries = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pull_en,
  output logic [nbits+1:0] pull_msg,
  input  logic             push_en,
  input  logic [nbits+1:0] push_msg,
  output logic             send_val,
  input  logic             send_rdy,
  output logic [nbits-1:0] send_msg,
  input  logic             recv_val,
  output logic             recv_rdy,
  input  logic [nbits-1:0] recv_msg,
  output logic [7:0]       drop_cnt
);

  localparam int PTR_W = (num_entries > 1) ? $clog2(num_entries) : 1;
  localparam int CNT_W = $clog2(num_entries + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(num_entries - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(num_entries);

  logic [nbits-1:0] req_mem [num_entries];
  logic [nbits-1:0] rsp_mem [num_entries];

  logic [PTR_W-1:0] req_wr_ptr_reg, req_rd_ptr_reg;
  logic [PTR_W-1:0] rsp_wr_ptr_reg, rsp_rd_ptr_reg;
  logic [CNT_W-1:0] req_count_reg, req_count_next;
  logic [CNT_W-1:0] rsp_count_reg, rsp_count_next;

  logic             snap_space_reg;
  logic             snap_valid_reg;
  logic [nbits-1:0] snap_data_reg;
  logic             recv_rdy_reg;
  logic [7:0]       drop_cnt_reg;

  logic             push_wr, push_rd;
  logic [nbits-1:0] push_data;
  logic             req_full, rsp_empty;
  logic             req_enq, req_deq, rsp_enq, rsp_deq, drop_now;
  logic [nbits-1:0] rsp_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign push_wr   = push_msg[nbits+1];
  assign push_rd   = push_msg[nbits];
  assign push_data = push_msg[nbits-1:0];

  assign req_full  = (req_count_reg == FULL_CNT);
  assign rsp_empty = (rsp_count_reg == '0);
  assign rsp_head  = rsp_mem[rsp_rd_ptr_reg];

  // Frame-end decisions use only the snapshot, so they cannot overflow or underflow.
  assign req_enq  = push_en & push_wr & snap_space_reg;
  assign drop_now = push_en & push_wr & ~snap_space_reg;
  assign rsp_deq  = push_en & push_rd & snap_valid_reg;
  assign req_deq  = send_val & send_rdy;
  assign rsp_enq  = recv_val & recv_rdy_reg;

  always_comb begin
    req_count_next = req_count_reg;
    if (req_enq && !req_deq)
      req_count_next = req_count_reg + CNT_W'(1);
    else if (!req_enq && req_deq)
      req_count_next = req_count_reg - CNT_W'(1);
  end

  always_comb begin
    rsp_count_next = rsp_count_reg;
    if (rsp_enq && !rsp_deq)
      rsp_count_next = rsp_count_reg + CNT_W'(1);
    else if (!rsp_enq && rsp_deq)
      rsp_count_next = rsp_count_reg - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (req_enq) req_mem[req_wr_ptr_reg] <= push_data;
    if (rsp_enq) rsp_mem[rsp_wr_ptr_reg] <= recv_msg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_wr_ptr_reg <= '0;
      req_rd_ptr_reg <= '0;
      rsp_wr_ptr_reg <= '0;
      rsp_rd_ptr_reg <= '0;
      req_count_reg  <= '0;
      rsp_count_reg  <= '0;
      snap_space_reg <= 1'b0;
      snap_valid_reg <= 1'b0;
      snap_data_reg  <= '0;
      recv_rdy_reg   <= 1'b0;
      drop_cnt_reg   <= '0;
    end else begin
      if (req_enq) req_wr_ptr_reg <= ptr_inc(req_wr_ptr_reg);
      if (req_deq) req_rd_ptr_reg <= ptr_inc(req_rd_ptr_reg);
      if (rsp_enq) rsp_wr_ptr_reg <= ptr_inc(rsp_wr_ptr_reg);
      if (rsp_deq) rsp_rd_ptr_reg <= ptr_inc(rsp_rd_ptr_reg);
      req_count_reg <= req_count_next;
      rsp_count_reg <= rsp_count_next;
      recv_rdy_reg  <= (rsp_count_next != FULL_CNT);
      if (drop_now && drop_cnt_reg != 8'hFF)
        drop_cnt_reg <= drop_cnt_reg + 8'd1;
      // A simultaneous pull wins: the push already committed with the old snapshot.
      if (pull_en) begin
        snap_space_reg <= ~req_full;
        snap_valid_reg <= ~rsp_empty;
        snap_data_reg  <= rsp_empty ? '0 : rsp_head;
      end else if (push_en) begin
        snap_space_reg <= 1'b0;
        snap_valid_reg <= 1'b0;
        snap_data_reg  <= '0;
      end
    end
  end

  assign pull_msg = {snap_space_reg, snap_valid_reg, snap_data_reg};
  assign send_val = (req_count_reg != '0);
  assign send_msg = send_val ? req_mem[req_rd_ptr_reg] : '0;
  assign recv_rdy = recv_rdy_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule

// File: doc/spi_minion_adapter.md
# spi_minion_adapter

Frame-level controller that sits behind the SPI minion's push/pull port and turns SPI transactions into val/rdy streams. Each SPI frame carries one request word from the master and returns one response word, with two flow-control bits in each direction. The adapter owns a request queue (SPI → `send_*`) and a response queue (`recv_*` → SPI). It snapshots queue status at frame start (`pull_en`) and commits enqueue/dequeue at frame end (`push_en`).

## Interface
- `nbits`, default 8: payload width; the SPI frame is `nbits+2` bits.
- `num_entries`, default 2: depth of each queue; must be ≥1.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `pull_en`  in  1  frame-start strobe from the minion; one cycle.
- `pull_msg`  out  nbits+2  word shifted out to the master: `[nbits+1]` = space, `[nbits]` = rsp_valid, `[nbits-1:0]` = response data.
- `push_en`  in  1  frame-end strobe from the minion; one cycle.
- `push_msg`  in  nbits+2  word received from the master: `[nbits+1]` = wr, `[nbits]` = rd, `[nbits-1:0]` = request data.
- `send_val`  out  1  request-queue head valid.
- `send_rdy`  in  1  consumer accepts the head.
- `send_msg`  out  nbits  request-queue head data.
- `recv_val`  in  1  producer offers a response.
- `recv_rdy`  out  1  response queue not full.
- `recv_msg`  in  nbits  response data.
- `drop_cnt`  out  8  saturating count of dropped master writes.

## Operation
- Two FIFOs, each with `num_entries` entries, read/write pointers that wrap modulo `num_entries`, and an occupancy count of width clog2(`num_entries`+1).
- Snapshot register `{snap_space, snap_valid, snap_data}` drives `pull_msg` directly from a flop.
- On `pull_en`, load the snapshot from pre-update state in the same cycle:
  - `snap_space` = request queue not full.
  - `snap_valid` = response queue not empty.
  - `snap_data` = response head if not empty, else 0.
- On `push_en`:
  - If wr=1 and `snap_space`=1: enqueue `push_msg[nbits-1:0]` into the request queue.
  - If wr=1 and `snap_space`=0: drop the data and increment `drop_cnt`, saturating at 255.
  - If rd=1 and `snap_valid`=1: dequeue the response head, which was the word sent this frame.
  - If rd=1 and `snap_valid`=0: no action.
  - If rd=0: the response stays queued, so the master re-reads it next frame.
  - After any `push_en`, clear the snapshot to 0. A second `push_en` without an intervening `pull_en` therefore drops writes and ignores reads.
- Consistency guarantee: only `push_en` fills the request queue and drains the response queue. Between pull and push, request space can only grow and the response head cannot change, so snapshot decisions never overflow or underflow.
- Stream side:
  - `send_val` = request queue not empty; `send_msg` = its head.
  - Pop when `send_val & send_rdy`.
  - `recv_rdy` = response queue not full; push when `recv_val & recv_rdy`.
- A queue may enqueue and dequeue in the same cycle, including when full or empty at a depth of 1 or more. Occupancy is unchanged and data order is preserved.

## Timing
- Reset values:
  - `pull_msg`=0, `send_val`=0, `send_msg`=0, `drop_cnt`=0.
  - `recv_rdy`=0 during the reset cycle and 1 from the first post-reset cycle.
  - Both queues are emptied and the snapshot is cleared.
- `pull_msg` is valid the cycle after `pull_en` and holds until the next `pull_en`, `push_en` or reset.
- A word pushed by the master appears on `send_*` the cycle after `push_en`. Latency is 1 cycle; `send_msg` is driven from queue storage.
- A `recv` handshake in cycle N is visible to a `pull_en` at cycle N+1 or later. A `pull_en` in the same cycle N sees the old occupancy.
- `recv_rdy` and `send_val` reflect registered occupancy. There is no combinational path from `send_rdy` to `recv_rdy` or in reverse.
- `pull_en` and `push_en` in the same cycle: commit the push using the old snapshot, then load the new snapshot from pre-update state. This order is legal but unexpected.
- Reset asserted mid-frame: the frame is abandoned and a later `push_en` without a new `pull_en` is treated as a drop.

## Test plan
- Reset, then frame with push {wr=1, rd=0, 0xA5}. Required: first `pull_msg`=0x200 (space=1, rsp_valid=0, data 0); `send_val`=1 with `send_msg`=0xA5 one cycle after `push_en`.
- `recv_msg`=0x3C accepted, then frame with rd=1. Required: `pull_msg`=0x33C; after push, response queue empty; next frame `pull_msg`=0x200.
- Same response, frame with rd=0. Required: no dequeue; next frame returns 0x33C again.
- `num_entries`=2, `send_rdy`=0, three write frames 0x11, 0x22, 0x33. Required: third frame `pull_msg[9]`=0; 0x33 dropped; `drop_cnt`=1; draining yields 0x11 then 0x22.
- Fill the response queue, hold `recv_val`=1, and issue a rd frame. Required: `recv_rdy` rises the cycle after the dequeue; simultaneous recv enqueue and push dequeue keep order.
- `push_en` without `pull_en` after reset, with wr=1. Required: `drop_cnt` increments. Reset asserted mid-frame. Required: all outputs return to reset values the next cycle.
